cond_exec_unit: RTL and testbench

//  Execute-stage condition unit for the pipelined ARM core, with an architectural NZCV register.

---
 rtl/cond_exec_unit.sv | 159 +++++++++++++++
 tb/tb_cond_exec_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cond_exec_unit.sv
// Execute-stage condition unit: ARM condition evaluation against the committed NZCV
// register, enable gating, and an IT predication block tracked by a two-state FSM.
module cond_exec_unit #(
    parameter int  IT_MAX = 4,
    localparam int CNT_W  = $clog2(IT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallE,
    input  logic              FlushE,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              Branch,
    input  logic              ITStart,
    input  logic [3:0]        ITCond,
    input  logic [CNT_W-1:0]  ITLen,
    input  logic [IT_MAX-1:0] ITPat,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              BranchTakenE,
    output logic [3:0]        FlagsQ,
    output logic              ITActive,
    output logic [CNT_W-1:0]  ITRemain,
    output logic              ITErr
);

    typedef enum logic {IDLE, ACTIVE} it_state_e;

    it_state_e          state_q, state_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [3:0]         it_cond_q, it_cond_d;
    logic [IT_MAX-1:0]  pat_q, pat_d;
    logic               err_q, err_d;

    logic               valid;
    logic               cond_ex;
    logic               len_ok;
    logic [3:0]         eff_cond;
    logic [CNT_W-1:0]   slot;
    logic [IT_MAX-1:0]  pat_shift;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cf;
            4'b0011: cond_eval = ~cf;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cf & ~z;
            4'b1001: cond_eval = ~cf | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign valid  = ~reset & ~StallE & ~FlushE;
    assign len_ok = (ITLen != '0) && (ITLen <= CNT_W'(IT_MAX));

    // Slot index counts up from 0 as remain counts down from len.
    assign slot      = len_q - remain_q;
    assign pat_shift = pat_q >> slot;

    always_comb begin
        eff_cond = Cond;
        if (state_q == ACTIVE)
            eff_cond = pat_shift[0] ? it_cond_q : {it_cond_q[3:1], ~it_cond_q[0]};
    end

    assign cond_ex      = cond_eval(eff_cond, flags_q);
    assign PCSrc        = PCS    & cond_ex & valid;
    assign RegWrite     = RegW   & cond_ex & valid;
    assign MemWrite     = MemW   & cond_ex & valid;
    assign BranchTakenE = Branch & cond_ex & valid;

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        remain_d  = remain_q;
        len_d     = len_q;
        it_cond_d = it_cond_q;
        pat_d     = pat_q;
        err_d     = 1'b0;

        if (valid && cond_ex) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end

        case (state_q)
            IDLE: begin
                if (valid && ITStart) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else if (cond_ex) begin
                        state_d   = ACTIVE;
                        remain_d  = ITLen;
                        len_d     = ITLen;
                        it_cond_d = ITCond;
                        pat_d     = ITPat;
                    end
                end
            end
            ACTIVE: begin
                if (valid) begin
                    // A nested IT is flagged but still burns its slot.
                    err_d    = ITStart;
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1) || PCSrc || BranchTakenE) begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            flags_q   <= '0;
            remain_q  <= '0;
            len_q     <= '0;
            it_cond_q <= '0;
            pat_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            remain_q  <= remain_d;
            len_q     <= len_d;
            it_cond_q <= it_cond_d;
            pat_q     <= pat_d;
            err_q     <= err_d;
        end
    end

    assign FlagsQ   = flags_q;
    assign ITActive = (state_q == ACTIVE);
    assign ITRemain = remain_q;
    assign ITErr    = err_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: the driver queues hand-computed expectations per
// cycle, a negedge monitor pops and compares them against the DUT outputs.
module tb_cond_exec_unit;

    localparam int IT_MAX = 4;
    localparam int CNT_W  = $clog2(IT_MAX + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              StallE, FlushE;
    logic [3:0]        Cond, ALUFlags;
    logic [1:0]        FlagW;
    logic              PCS, RegW, MemW, Branch;
    logic              ITStart;
    logic [3:0]        ITCond;
    logic [CNT_W-1:0]  ITLen;
    logic [IT_MAX-1:0] ITPat;
    logic              PCSrc, RegWrite, MemWrite, BranchTakenE;
    logic [3:0]        FlagsQ;
    logic              ITActive;
    logic [CNT_W-1:0]  ITRemain;
    logic              ITErr;

    cond_exec_unit #(.IT_MAX(IT_MAX)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITPat(ITPat),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .BranchTakenE(BranchTakenE),
        .FlagsQ(FlagsQ), .ITActive(ITActive), .ITRemain(ITRemain), .ITErr(ITErr)
    );

    always #5 clk = ~clk;

    // {PCSrc,RegWrite,MemWrite,BranchTakenE, FlagsQ, ITActive, ITRemain, ITErr}
    typedef struct {
        string       name;
        logic [12:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [3:0] EQ = 4'b0000, NE = 4'b0001, MI = 4'b0100, GE = 4'b1010, AL = 4'b1110;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [12:0] got;
            e   = exp_q.pop_front();
            got = {PCSrc, RegWrite, MemWrite, BranchTakenE, FlagsQ, ITActive, ITRemain, ITErr};
            n_checks++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got en=%b flags=%b act=%b rem=%0d err=%b, want en=%b flags=%b act=%b rem=%0d err=%b",
                         e.name, got[12:9], got[8:5], got[4], got[3:1], got[0],
                         e.exp[12:9], e.exp[8:5], e.exp[4], e.exp[3:1], e.exp[0]);
            end
        end
    end

    task automatic clr();
        StallE = 0; FlushE = 0; Cond = AL; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; Branch = 0;
        ITStart = 0; ITCond = EQ; ITLen = 0; ITPat = 0;
    endtask

    // en = {PCSrc,RegWrite,MemWrite,BranchTakenE}
    task automatic chk(input string name, input logic [3:0] en, input logic [3:0] fl,
                       input logic act, input logic [CNT_W-1:0] rem, input logic err);
        exp_t e;
        e.name = name;
        e.exp  = {en, fl, act, rem, err};
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic it_start(input logic [3:0] c, input logic [CNT_W-1:0] len, input logic [IT_MAX-1:0] pat);
        ITStart = 1; ITCond = c; ITLen = len; ITPat = pat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        reset = 1; RegW = 1; PCS = 1;
        tick();
        chk("reset_state", 4'b0000, 4'b0000, 0, 0, 0);
        tick();
        reset = 0; clr();

        // Flags start at 0: EQ fails; AL writes flags; EQ then passes.
        Cond = EQ; RegW = 1;               chk("eq_flags0", 4'b0000, 4'b0000, 0, 0, 0); tick(); clr();
        FlagW = 2'b11; ALUFlags = 4'b0100; chk("al_flagw", 4'b0000, 4'b0000, 0, 0, 0); tick(); clr();
        Cond = EQ; RegW = 1;               chk("eq_flagsZ", 4'b0100, 4'b0100, 0, 0, 0); tick(); clr();

        // IT EQ len3 pat 101; Cond input must be ignored while active.
        it_start(EQ, 3, 4'b0101);          chk("it_start", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        Cond = NE; RegW = 1;               chk("it_s0", 4'b0100, 4'b0100, 1, 3, 0); tick(); clr();
        RegW = 1;                          chk("it_s1", 4'b0000, 4'b0100, 1, 2, 0); tick(); clr();
        RegW = 1;                          chk("it_s2", 4'b0100, 4'b0100, 1, 1, 0); tick(); clr();
        chk("it_done", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();

        // Same block with a 2-cycle stall on slot 1.
        it_start(EQ, 3, 4'b0101);          chk("st_start", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        RegW = 1; MemW = 1;                chk("st_s0", 4'b0110, 4'b0100, 1, 3, 0); tick(); clr();
        StallE = 1; RegW = 1;              chk("st_hold1", 4'b0000, 4'b0100, 1, 2, 0); tick(); clr();
        StallE = 1; RegW = 1;              chk("st_hold2", 4'b0000, 4'b0100, 1, 2, 0); tick(); clr();
        RegW = 1;                          chk("st_s1", 4'b0000, 4'b0100, 1, 2, 0); tick(); clr();
        RegW = 1;                          chk("st_s2", 4'b0100, 4'b0100, 1, 1, 0); tick(); clr();
        chk("st_done", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();

        // Taken branch in slot 1 ends a 4-slot block early.
        it_start(EQ, 4, 4'b1111);          chk("br_start", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        RegW = 1;                          chk("br_s0", 4'b0100, 4'b0100, 1, 4, 0); tick(); clr();
        Branch = 1;                        chk("br_s1", 4'b0001, 4'b0100, 1, 3, 0); tick(); clr();
        chk("br_exit", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();

        // Malformed lengths.
        it_start(EQ, 0, 4'b1111);          chk("len0_issue", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        chk("len0_err", 4'b0000, 4'b0100, 0, 0, 1); tick(); clr();
        chk("len0_clear", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        it_start(EQ, 5, 4'b1111);          chk("len5_issue", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        chk("len5_err", 4'b0000, 4'b0100, 0, 0, 1); tick(); clr();
        chk("len5_clear", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();

        // Nested IT in slot 1; last slot also writes flags to 0.
        it_start(EQ, 3, 4'b0111);          chk("nest_start", 4'b0000, 4'b0100, 0, 0, 0); tick(); clr();
        RegW = 1;                          chk("nest_s0", 4'b0100, 4'b0100, 1, 3, 0); tick(); clr();
        it_start(EQ, 4, 4'b1111);          chk("nest_s1", 4'b0000, 4'b0100, 1, 2, 0); tick(); clr();
        RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0000;
                                           chk("nest_s2_err", 4'b0100, 4'b0100, 1, 1, 1); tick(); clr();
        Cond = EQ; RegW = 1;               chk("last_slot_flags", 4'b0000, 4'b0000, 0, 0, 0); tick(); clr();

        // Partial flag writes, failed-cond no-write, flush no-write.
        FlagW = 2'b11; ALUFlags = 4'b1010; chk("set_nc", 4'b0000, 4'b0000, 0, 0, 0); tick(); clr();
        Cond = MI; RegW = 1; FlagW = 2'b01; ALUFlags = 4'b0101;
                                           chk("mi_cv_write", 4'b0100, 4'b1010, 0, 0, 0); tick(); clr();
        Cond = EQ; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0100;
                                           chk("eq_fail_nowr", 4'b0000, 4'b1001, 0, 0, 0); tick(); clr();
        Cond = GE; RegW = 1;               chk("ge_pass", 4'b0100, 4'b1001, 0, 0, 0); tick(); clr();
        FlushE = 1; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0000;
                                           chk("flush", 4'b0000, 4'b1001, 0, 0, 0); tick(); clr();

        // Reset mid-block in slot 2.
        it_start(MI, 4, 4'b1111);          chk("rst_start", 4'b0000, 4'b1001, 0, 0, 0); tick(); clr();
        RegW = 1;                          chk("rst_s0", 4'b0100, 4'b1001, 1, 4, 0); tick(); clr();
        RegW = 1;                          chk("rst_s1", 4'b0100, 4'b1001, 1, 3, 0); tick(); clr();
        reset = 1; RegW = 1;               chk("rst_s2", 4'b0000, 4'b1001, 1, 2, 0); tick(); clr();
        RegW = 1; PCS = 1;                 chk("rst_after", 4'b0000, 4'b0000, 0, 0, 0); tick(); clr();
        reset = 0; RegW = 1;               chk("rst_release", 4'b0100, 4'b0000, 0, 0, 0); tick(); clr();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
